// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_AUX  = 2'd2
    } owner_t;

    localparam logic [3:0] WE_NONE = 4'b0000;
    localparam logic [3:0] WE_WORD = 4'b1111;

    function automatic logic is_read(input logic [3:0] we);
        return (we & WE_WORD) == WE_NONE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the CPU, auxiliary and BRAM-side signals of the shared memory port.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic              cpu_req;
    logic [3:0]        cpu_we;
    logic [ADDR_W-1:0] cpu_adr;
    logic [DATA_W-1:0] cpu_din;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_dout;

    logic              aux_req;
    logic [3:0]        aux_we;
    logic [ADDR_W-1:0] aux_adr;
    logic [DATA_W-1:0] aux_din;
    logic              aux_gnt;
    logic              aux_rvalid;
    logic [DATA_W-1:0] aux_dout;

    logic [ADDR_W-1:0] mem_adr;
    logic [3:0]        mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    // Requesters and BRAM side.
    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_din,
        output aux_req, aux_we, aux_adr, aux_din,
        output mem_dout,
        input  cpu_stall, cpu_rvalid, cpu_dout,
        input  aux_gnt, aux_rvalid, aux_dout,
        input  mem_adr, mem_we, mem_din
    );

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_din,
        input  aux_req, aux_we, aux_adr, aux_din,
        input  mem_dout,
        output cpu_stall, cpu_rvalid, cpu_dout,
        output aux_gnt, aux_rvalid, aux_dout,
        output mem_adr, mem_we, mem_din
    );
endinterface

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; reset and clear take priority over increment.
module sat_counter #(
    parameter int unsigned     WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single dmem BRAM port between the CPU and an auxiliary requester.
// Optional statistics counters are built when MEM_PORT_ARB_STATS_EN is defined.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus
`ifdef MEM_PORT_ARB_STATS_EN
    ,
    output logic [15:0]           stat_stall_cnt,
    output logic [15:0]           stat_aux_cnt
`endif
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]        starve_cnt;
    logic [3:0]        starve_eff;
    logic              starve_inc;
    logic              starve_clr;
    logic              aux_win;
    logic              cpu_win;
    logic              stall;
    logic [ADDR_W-1:0] adr_sel;
    logic [DATA_W-1:0] din_sel;
    logic [3:0]        we_sel;
    owner_t            owner_q;
    owner_t            owner_d;

    // While rst is high the register may still hold a stale count; arbitrate as if cleared.
    assign starve_eff = rst ? '0 : starve_cnt;

    always_comb begin
        aux_win = bus.aux_req && (!bus.cpu_req || (starve_eff == STARVE_LIM));
        cpu_win = bus.cpu_req && !aux_win;
        stall   = bus.cpu_req && !cpu_win;
    end

    always_comb begin
        adr_sel = bus.cpu_adr;
        din_sel = bus.cpu_din;
        we_sel  = WE_NONE;
        if (aux_win) begin
            adr_sel = bus.aux_adr;
            din_sel = bus.aux_din;
            we_sel  = bus.aux_we;
        end else if (cpu_win) begin
            we_sel  = bus.cpu_we;
        end
    end

    assign bus.mem_adr   = adr_sel;
    assign bus.mem_din   = din_sel;
    assign bus.mem_we    = we_sel;
    assign bus.cpu_stall = stall;
    assign bus.aux_gnt   = aux_win;

    assign starve_inc = bus.aux_req && !aux_win;
    assign starve_clr = !starve_inc;

    sat_counter #(
        .WIDTH (4),
        .MAX   (STARVE_LIM)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .clr (starve_clr),
        .inc (starve_inc),
        .cnt (starve_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (aux_win && is_read(bus.aux_we)) begin
            owner_d = OWN_AUX;
        end else if (cpu_win && is_read(bus.cpu_we)) begin
            owner_d = OWN_CPU;
        end
    end

    // Gating with rst drops a read return that is pending when reset arrives.
    assign bus.cpu_rvalid = !rst && (owner_q == OWN_CPU);
    assign bus.aux_rvalid = !rst && (owner_q == OWN_AUX);
    assign bus.cpu_dout   = bus.mem_dout;
    assign bus.aux_dout   = bus.mem_dout;

`ifdef MEM_PORT_ARB_STATS_EN
    sat_counter #(
        .WIDTH (16),
        .MAX   (16'hFFFF)
    ) u_stat_stall (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (stall),
        .cnt (stat_stall_cnt)
    );

    sat_counter #(
        .WIDTH (16),
        .MAX   (16'hFFFF)
    ) u_stat_aux (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (aux_win),
        .cnt (stat_aux_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed cycles push expectations, a negedge monitor checks them.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef MEM_PORT_ARB_STATS_EN
    logic [15:0] stat_stall_cnt;
    logic [15:0] stat_aux_cnt;
`endif

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MEM_PORT_ARB_STATS_EN
        ,
        .stat_stall_cnt (stat_stall_cnt),
        .stat_aux_cnt   (stat_aux_cnt)
`endif
    );

    // BRAM stand-in: one-cycle read latency, data tagged with the address read.
    always @(posedge clk) bus.mem_dout <= {20'hC0DE0, bus.mem_adr};

    typedef struct {
        logic        stall;
        logic        gnt;
        logic [11:0] adr;
        logic [3:0]  we;
        logic        chk_din;
        logic [31:0] din;
        logic        crv;
        logic        arv;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] cpu_dq[$];
    logic [31:0] aux_dq[$];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("cpu_stall",  32'(bus.cpu_stall),  32'(e.stall));
            check("aux_gnt",    32'(bus.aux_gnt),    32'(e.gnt));
            check("mem_adr",    32'(bus.mem_adr),    32'(e.adr));
            check("mem_we",     32'(bus.mem_we),     32'(e.we));
            if (e.chk_din) check("mem_din", bus.mem_din, e.din);
            check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(e.crv));
            check("aux_rvalid", 32'(bus.aux_rvalid), 32'(e.arv));
            if (bus.cpu_rvalid) begin
                if (cpu_dq.size() == 0) check("cpu_dout_unexpected", 32'd1, 32'd0);
                else check("cpu_dout", bus.cpu_dout, cpu_dq.pop_front());
            end
            if (bus.aux_rvalid) begin
                if (aux_dq.size() == 0) check("aux_dout_unexpected", 32'd1, 32'd0);
                else check("aux_dout", bus.aux_dout, aux_dq.pop_front());
            end
        end
    end

    task automatic cyc(
        input logic r,
        input logic creq, input logic [3:0] cwe, input logic [11:0] cadr, input logic [31:0] cdin,
        input logic areq, input logic [3:0] awe, input logic [11:0] aadr, input logic [31:0] adin,
        input logic e_stall, input logic e_gnt, input logic [11:0] e_adr, input logic [3:0] e_we,
        input logic chk_din, input logic [31:0] e_din, input logic e_crv, input logic e_arv
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_adr = cadr; bus.cpu_din = cdin;
        bus.aux_req = areq; bus.aux_we = awe; bus.aux_adr = aadr; bus.aux_din = adin;
        e.stall = e_stall; e.gnt = e_gnt; e.adr = e_adr; e.we = e_we;
        e.chk_din = chk_din; e.din = e_din; e.crv = e_crv; e.arv = e_arv;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [11:0] cadr, input logic crv, input logic arv);
        cyc(1'b0, 1'b0, WE_NONE, cadr, '0, 1'b0, WE_NONE, '0, '0,
            1'b0, 1'b0, cadr, WE_NONE, 1'b0, '0, crv, arv);
    endtask

    // Continuous contention starting from an idle cycle: aux wins cycles 5, 10, 15, ...
    task automatic contend(input int unsigned n, input logic [11:0] cadr, input logic [11:0] aadr);
        for (int unsigned k = 1; k <= n; k++) begin
            logic aw, pa, pc;
            aw = (k % 5) == 0;
            pa = (k > 1) && (((k - 1) % 5) == 0);
            pc = (k > 1) && !pa;
            cyc(1'b0, 1'b1, WE_NONE, cadr, '0, 1'b1, WE_NONE, aadr, '0,
                aw, aw, aw ? aadr : cadr, WE_NONE, 1'b0, '0, pc, pa);
            if (aw) aux_dq.push_back({20'hC0DE0, aadr});
            else    cpu_dq.push_back({20'hC0DE0, cadr});
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = WE_NONE; bus.cpu_adr = '0; bus.cpu_din = '0;
        bus.aux_req = 1'b0; bus.aux_we = WE_NONE; bus.aux_adr = '0; bus.aux_din = '0;

        // Reset state
        repeat (2) cyc(1'b1, 1'b0, WE_NONE, 12'h000, '0, 1'b0, WE_NONE, '0, '0,
                       1'b0, 1'b0, 12'h000, WE_NONE, 1'b0, '0, 1'b0, 1'b0);

        // CPU-only read of 0x010, returned next cycle
        cyc(1'b0, 1'b1, WE_NONE, 12'h010, '0, 1'b0, WE_NONE, '0, '0,
            1'b0, 1'b0, 12'h010, WE_NONE, 1'b0, '0, 1'b0, 1'b0);
        cpu_dq.push_back(32'hC0DE0010);
        idle(12'h010, 1'b1, 1'b0);

        // Aux word write, no read return afterwards
        cyc(1'b0, 1'b0, WE_NONE, 12'h000, '0, 1'b1, WE_WORD, 12'h3FF, 32'hDEADBEEF,
            1'b0, 1'b1, 12'h3FF, WE_WORD, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        idle(12'h000, 1'b0, 1'b0);

        // Alternating CPU then aux reads, each rvalid one cycle wide
        cyc(1'b0, 1'b1, WE_NONE, 12'h020, '0, 1'b0, WE_NONE, '0, '0,
            1'b0, 1'b0, 12'h020, WE_NONE, 1'b0, '0, 1'b0, 1'b0);
        cpu_dq.push_back(32'hC0DE0020);
        cyc(1'b0, 1'b0, WE_NONE, 12'h020, '0, 1'b1, WE_NONE, 12'h030, '0,
            1'b0, 1'b1, 12'h030, WE_NONE, 1'b0, '0, 1'b1, 1'b0);
        aux_dq.push_back(32'hC0DE0030);
        idle(12'h020, 1'b0, 1'b1);
        idle(12'h020, 1'b0, 1'b0);

        // Contention: aux granted in cycles 5 and 10 only
        contend(10, 12'h040, 12'h050);
        idle(12'h040, 1'b0, 1'b1);

        // Build the starve count to 4, then reset right after a granted CPU read
        for (int unsigned k = 1; k <= 4; k++) begin
            cyc(1'b0, 1'b1, WE_NONE, 12'h060, '0, 1'b1, WE_NONE, 12'h070, '0,
                1'b0, 1'b0, 12'h060, WE_NONE, 1'b0, '0, k > 1, 1'b0);
            if (k < 4) cpu_dq.push_back(32'hC0DE0060);
        end
        // In reset the stale count must not let aux win, and the pending rvalid is dropped
        cyc(1'b1, 1'b1, WE_NONE, 12'h060, '0, 1'b1, WE_NONE, 12'h070, '0,
            1'b0, 1'b0, 12'h060, WE_NONE, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, WE_NONE, 12'h060, '0, 1'b1, WE_NONE, 12'h070, '0,
            1'b0, 1'b0, 12'h060, WE_NONE, 1'b0, '0, 1'b0, 1'b0);
        cpu_dq.push_back(32'hC0DE0060);
        idle(12'h060, 1'b1, 1'b0);

        // Three full starvation rounds: three stalls and three aux grants since reset
        contend(15, 12'h080, 12'h090);
        idle(12'h080, 1'b0, 1'b1);

        @(negedge clk);
        #1;
`ifdef MEM_PORT_ARB_STATS_EN
        check("stat_stall_cnt", 32'(stat_stall_cnt), 32'd3);
        check("stat_aux_cnt",   32'(stat_aux_cnt),   32'd3);
`endif
        check("exp_q_drained",  32'(exp_q.size()),  32'd0);
        check("cpu_dq_drained", 32'(cpu_dq.size()), 32'd0);
        check("aux_dq_drained", 32'(aux_dq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
